// File: rtl/frame_chan_serializer.sv
// Header-locked frame parser with CRC-16/CCITT-FALSE check, one-deep hold buffer and
// NUM_CH-lane MSB-first serializer. Define FRAME_CHAN_GRAY_EN to serialize payload in Gray code.
module frame_chan_serializer #(
   parameter int          NUM_CH  = 8,
   parameter logic [15:0] HEADER  = 16'hE0E0,
   parameter int          TIMEOUT = 64
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [15:0]       data_in,
   input  logic              data_in_vld,
   output logic [NUM_CH-1:0] data_out,
   output logic [NUM_CH-1:0] data_vld,
   output logic              crc_valid,
   output logic              crc_err,
   output logic              frame_drop,
   output logic              frame_abort,
   output logic              busy
);

   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);
   localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CTRL  = 2'd1,
      S_DATA  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   // CRC-16/CCITT-FALSE, one full word per call, MSB first.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] word);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int b = 15; b >= 0; b--) begin
         fb = c[15] ^ word[b];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   function automatic logic [15:0] lane_word(input logic [15:0] w);
`ifdef FRAME_CHAN_GRAY_EN
      return w ^ (w >> 1);
`else
      return w;
`endif
   endfunction

   // Parser state
   state_t            r_state;
   logic [15:0]       r_crc;
   logic [SW-1:0]     r_slot;
   logic [TW-1:0]     r_idle_cnt;
   logic [NUM_CH-1:0] r_rx_mask;
   logic [15:0]       r_rx_data [NUM_CH];
   logic              r_crc_valid;
   logic              r_crc_err;
   logic              r_frame_drop;
   logic              r_frame_abort;

   // Hold buffer
   logic              r_hold_full;
   logic [NUM_CH-1:0] r_hold_mask;
   logic [15:0]       r_hold_data [NUM_CH];

   // Serializer
   logic              r_ser_active;
   logic [3:0]        r_bit_cnt;
   logic [NUM_CH-1:0] r_ser_mask;
   logic [15:0]       r_shreg [NUM_CH];

   logic [15:0] w_crc_next;
   logic        w_in_frame;
   logic        w_timeout;
   logic        w_pass;
   logic        w_fail;
   logic        w_load;
   logic        w_accept;

   assign w_crc_next = crc16_word(r_crc, data_in);
   assign w_in_frame = (r_state != S_IDLE);
   assign w_timeout  = w_in_frame && !data_in_vld && (r_idle_cnt == LAST_IDLE);
   assign w_pass     = (r_state == S_CHECK) && data_in_vld && (data_in == r_crc);
   assign w_fail     = (r_state == S_CHECK) && data_in_vld && (data_in != r_crc);
   // Loading on the last shifted bit keeps consecutive frames gapless.
   assign w_load     = r_hold_full && (!r_ser_active || (r_bit_cnt == 4'd15));
   // A load in the same cycle frees the hold slot before the new frame is written.
   assign w_accept   = w_pass && (!r_hold_full || w_load);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_crc         <= 16'hFFFF;
         r_slot        <= '0;
         r_idle_cnt    <= '0;
         r_rx_mask     <= '0;
         r_crc_valid   <= 1'b0;
         r_crc_err     <= 1'b0;
         r_frame_drop  <= 1'b0;
         r_frame_abort <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) r_rx_data[i] <= '0;
      end else begin
         r_crc_valid   <= 1'b0;
         r_crc_err     <= 1'b0;
         r_frame_drop  <= 1'b0;
         r_frame_abort <= 1'b0;

         if (!w_in_frame || data_in_vld) r_idle_cnt <= '0;
         else                            r_idle_cnt <= r_idle_cnt + 1'b1;

         if (w_timeout) begin
            r_frame_abort <= 1'b1;
            r_state       <= S_IDLE;
            r_crc         <= 16'hFFFF;
            r_idle_cnt    <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (data_in_vld && (data_in == HEADER)) r_state <= S_CTRL;
               end
               S_CTRL: begin
                  if (data_in_vld) begin
                     r_rx_mask <= data_in[NUM_CH-1:0];
                     r_crc     <= w_crc_next;
                     r_slot    <= '0;
                     r_state   <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (data_in_vld) begin
                     r_rx_data[r_slot] <= data_in;
                     r_crc             <= w_crc_next;
                     if (r_slot == LAST_SLOT) r_state <= S_CHECK;
                     else                     r_slot  <= r_slot + 1'b1;
                  end
               end
               S_CHECK: begin
                  if (data_in_vld) begin
                     r_crc_valid  <= w_pass;
                     r_crc_err    <= w_fail;
                     r_frame_drop <= w_pass && !w_accept;
                     r_crc        <= 16'hFFFF;
                     r_state      <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_full <= 1'b0;
         r_hold_mask <= '0;
         for (int i = 0; i < NUM_CH; i++) r_hold_data[i] <= '0;
      end else begin
         if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_mask <= r_rx_mask;
            for (int i = 0; i < NUM_CH; i++) r_hold_data[i] <= r_rx_data[i];
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_ser_active <= 1'b0;
         r_bit_cnt    <= '0;
         r_ser_mask   <= '0;
         for (int i = 0; i < NUM_CH; i++) r_shreg[i] <= '0;
      end else begin
         if (w_load) begin
            r_ser_active <= 1'b1;
            r_bit_cnt    <= '0;
            r_ser_mask   <= r_hold_mask;
            for (int i = 0; i < NUM_CH; i++) r_shreg[i] <= lane_word(r_hold_data[i]);
         end else if (r_ser_active) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            for (int i = 0; i < NUM_CH; i++) r_shreg[i] <= {r_shreg[i][14:0], 1'b0};
            if (r_bit_cnt == 4'd15) r_ser_active <= 1'b0;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign data_vld[gi] = r_ser_active & r_ser_mask[gi];
         assign data_out[gi] = r_ser_active & r_ser_mask[gi] & r_shreg[gi][15];
      end
   endgenerate

   assign crc_valid   = r_crc_valid;
   assign crc_err     = r_crc_err;
   assign frame_drop  = r_frame_drop;
   assign frame_abort = r_frame_abort;
   assign busy        = w_in_frame | r_hold_full | r_ser_active;

endmodule
